mosby: RTL and testbench

- Program-counter and branch unit of the MOSby 6502-style CPU.
- Holds the 16-bit PC and a byte-wide program ROM; the ROM is read combinationally at the PC.
- Executes decoder-issued PC increments, absolute jumps (two-byte target) and 6502 conditional relative branches evaluated against the status register.
- The decoder and status register sit outside this block and drive all control inputs.

---
 rtl/mosby_pkg.sv | 34 +++
 rtl/mosby_branch_cond.sv | 31 +++
 rtl/mosby.sv | 94 +++++++++
 tb/tb_mosby.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mosby_pkg.sv
// Shared definitions for the MOSby program-counter / branch unit:
// branch condition codes, status-register flag positions and reset PC.
package mosby_pkg;

   // 6502 relative-branch condition selects as issued by the decoder.
   typedef enum logic [2:0] {
      OP_BPL = 3'b000,  // N = 0
      OP_BMI = 3'b001,  // N = 1
      OP_BVC = 3'b010,  // V = 0
      OP_BVS = 3'b011,  // V = 1
      OP_BCC = 3'b100,  // C = 0
      OP_BCS = 3'b101,  // C = 1
      OP_BNE = 3'b110,  // Z = 0
      OP_BEQ = 3'b111   // Z = 1
   } branch_op_e;

   // Bit positions inside the P (processor status) register.
   localparam int unsigned FLAG_N = 32'd7;
   localparam int unsigned FLAG_V = 32'd6;
   localparam int unsigned FLAG_B = 32'd4;
   localparam int unsigned FLAG_D = 32'd3;
   localparam int unsigned FLAG_I = 32'd2;
   localparam int unsigned FLAG_Z = 32'd1;
   localparam int unsigned FLAG_C = 32'd0;

   // Default program counter after reset.
   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

   // Sign-extend an 8-bit relative branch offset to PC width.
   function automatic logic [15:0] sext8(input logic [7:0] b);
      return {{8{b[7]}}, b};
   endfunction

endpackage

// File: rtl/mosby_branch_cond.sv
// Combinational evaluation of a 6502 conditional-branch predicate
// from the branch_op select and the current status register.
module mosby_branch_cond
   import mosby_pkg::*;
(
   input  logic [2:0] branch_op,
   input  logic [7:0] status,
   output logic       cond
);

   // Bit 5, B, D and I play no part in branch decisions.
   logic unused_status_s;
   assign unused_status_s = ^{status[5], status[FLAG_B], status[FLAG_D], status[FLAG_I]};

   // Pick the flag named by branch_op and test it against the wanted polarity.
   always_comb begin
      cond = 1'b0;
      case (branch_op_e'(branch_op))
         OP_BPL:  cond = ~status[FLAG_N];
         OP_BMI:  cond =  status[FLAG_N];
         OP_BVC:  cond = ~status[FLAG_V];
         OP_BVS:  cond =  status[FLAG_V];
         OP_BCC:  cond = ~status[FLAG_C];
         OP_BCS:  cond =  status[FLAG_C];
         OP_BNE:  cond = ~status[FLAG_Z];
         OP_BEQ:  cond =  status[FLAG_Z];
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/mosby.sv
// MOSby program counter and branch unit: holds the PC and the program
// ROM, and applies increments, absolute jumps and relative branches.
module mosby
   import mosby_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int          ROM_AW    = 8,
   parameter string       INIT_FILE = "program.hex"
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_uncon,
   input  logic        branch_con,
   input  logic        pc_inc_decoder,
   input  logic        lower_byte_decoder,
   input  logic [2:0]  branch_op,
   input  logic [7:0]  status,
   output logic [15:0] pc,
   output logic [7:0]  rom_data,
   output logic        branch_taken
);

   localparam int ROM_DEPTH = 1 << ROM_AW;

   // Program image; read-only from the logic's point of view.
   logic [7:0] rom_mem [0:ROM_DEPTH-1];

   logic [15:0] pc_q;
   logic [15:0] pc_d;
   logic [7:0]  addr_lo_q;
   logic [7:0]  addr_lo_d;
   logic [15:0] pc_next_seq_s;
   logic        cond_s;

   // Clear the ROM image once at start of simulation.
   initial begin
      for (int i = 0; i < ROM_DEPTH; i++) begin
         rom_mem[i] = 8'h00;
      end
   end

   // Only the low ROM_AW bits index the ROM, so the image aliases upward.
   assign rom_data = rom_mem[pc_q[ROM_AW-1:0]];
   assign pc       = pc_q;

   mosby_branch_cond u_branch_cond (
      .branch_op (branch_op),
      .status    (status),
      .cond      (cond_s)
   );

   // Next-state for the target low byte and the PC priority mux.
   always_comb begin
      pc_next_seq_s = pc_q + 16'd1;
      pc_d          = pc_q;
      addr_lo_d     = addr_lo_q;
      branch_taken  = branch_uncon | (branch_con & cond_s);

      // Low-byte latch runs in parallel with whatever the PC does.
      if (lower_byte_decoder) begin
         addr_lo_d = rom_data;
      end else begin
         addr_lo_d = addr_lo_q;
      end

      // Jump uses the previously latched low byte, never the one latched now.
      if (branch_uncon) begin
         pc_d = {rom_data, addr_lo_q};
      end else if (branch_con) begin
         if (cond_s) begin
            pc_d = pc_next_seq_s + sext8(rom_data);
         end else begin
            pc_d = pc_next_seq_s;
         end
      end else if (pc_inc_decoder) begin
         pc_d = pc_next_seq_s;
      end else begin
         pc_d = pc_q;
      end
   end

   // PC and target-low-byte registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         addr_lo_q <= 8'h00;
      end else begin
         pc_q      <= pc_d;
         addr_lo_q <= addr_lo_d;
      end
   end

endmodule

// File: tb/tb_mosby.sv
// Self-checking bench for mosby: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_mosby;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        branch_uncon = 1'b0;
   logic        branch_con = 1'b0;
   logic        pc_inc_decoder = 1'b0;
   logic        lower_byte_decoder = 1'b0;
   logic [2:0]  branch_op = 3'd0;
   logic [7:0]  status = 8'd0;
   logic [15:0] pc;
   logic [7:0]  rom_data;
   logic        branch_taken;

   // Reference state
   logic [7:0]  rom_img [256];
   logic [15:0] m_pc = 16'h0000;
   logic [7:0]  m_lo = 8'h00;
   logic        m_taken = 1'b0;
   bit          check_en = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mosby #(.RESET_PC(16'h0000), .ROM_AW(8), .INIT_FILE("")) dut (
      .clk                (clk),
      .rst                (rst),
      .branch_uncon       (branch_uncon),
      .branch_con         (branch_con),
      .pc_inc_decoder     (pc_inc_decoder),
      .lower_byte_decoder (lower_byte_decoder),
      .branch_op          (branch_op),
      .status             (status),
      .pc                 (pc),
      .rom_data           (rom_data),
      .branch_taken       (branch_taken)
   );

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   // Branch predicate: opcode bits [2:1] pick N,V,C,Z; bit 0 is the wanted value.
   function automatic logic model_cond(input logic [2:0] op, input logic [7:0] st);
      int pos [4];
      pos = '{7, 6, 0, 1};
      return st[pos[op[2:1]]] == op[0];
   endfunction

   task automatic drive(input logic u, input logic c, input logic i, input logic l,
                        input logic [2:0] op, input logic [7:0] st);
      branch_uncon       = u;
      branch_con         = c;
      pc_inc_decoder     = i;
      lower_byte_decoder = l;
      branch_op          = op;
      status             = st;
      m_taken            = u | (c & model_cond(op, st));
   endtask

   // Advance one clock; the model applies the rules for the inputs held at the edge.
   task automatic tick();
      logic [7:0]  b;
      logic [15:0] nxt;
      int          off;
      int          t;
      @(posedge clk);
      if (!rst) begin
         b = rom_img[m_pc[7:0]];
         if (branch_uncon) nxt = {b, m_lo};
         else if (branch_con) begin
            off = 0;
            if (model_cond(branch_op, status))
               off = (int'(b) >= 128) ? int'(b) - 256 : int'(b);
            t   = int'(m_pc) + 1 + off;
            nxt = t[15:0];
         end
         else if (pc_inc_decoder) nxt = m_pc + 16'd1;
         else nxt = m_pc;
         if (lower_byte_decoder) m_lo = b;
         m_pc = nxt;
      end
      #1;
   endtask

   // Assert reset between edges, confirm it acts at once, release after one edge.
   task automatic reset_pulse();
      #2;
      rst  = 1'b1;
      m_pc = 16'h0000;
      m_lo = 8'h00;
      #1;
      check("async_reset_pc", pc, 16'h0000);
      tick();
      rst = 1'b0;
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (check_en) begin
         check("pc", pc, m_pc);
         check("rom_data", {8'h00, rom_data}, {8'h00, rom_img[m_pc[7:0]]});
         check("branch_taken", {15'd0, branch_taken}, {15'd0, m_taken});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      for (int i = 0; i < 256; i++) rom_img[i] = 8'($urandom);
      rom_img[8'h00] = 8'h34;
      rom_img[8'h01] = 8'h12;
      rom_img[8'h10] = 8'hFC;
      rom_img[8'h12] = 8'hAB;
      rom_img[8'h20] = 8'hFF;
      rom_img[8'h21] = 8'hFF;
      #1;
      for (int i = 0; i < 256; i++) dut.rom_mem[i] = rom_img[i];

      // Reset then increment
      #5;                       // t=6
      rst      = 1'b1;
      m_pc     = 16'h0000;
      m_lo     = 8'h00;
      check_en = 1'b1;
      #3;                       // t=9
      check("reset_pc", pc, 16'h0000);
      #10;                      // t=19
      rst = 1'b0;
      repeat (10) tick();
      check("inc_after_10", pc, 16'd10);
      check("inc_no_taken", {15'd0, branch_taken}, 16'd0);

      // Async reset mid-run, incrementing resumes
      reset_pulse();
      repeat (5) tick();
      check("resume_inc", pc, 16'd5);

      // Absolute jump
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      reset_pulse();
      check("rom_at_0", {8'h00, rom_data}, 16'h0034);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00);
      tick();
      check("jmp_step1_pc", pc, 16'h0001);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      #1;
      check("jmp_taken", {15'd0, branch_taken}, 16'd1);
      tick();
      check("jmp_target", pc, 16'h1234);

      // Conditional branch taken with negative offset
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      reset_pulse();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      repeat (16) tick();
      check("at_10h", pc, 16'h0010);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 8'h02);
      #1;
      check("beq_taken", {15'd0, branch_taken}, 16'd1);
      tick();
      check("beq_neg_target", pc, 16'h000D);

      // Not-taken BEQ, then not-taken BPL
      drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      repeat (3) tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 8'h00);
      #1;
      check("beq_not_taken", {15'd0, branch_taken}, 16'd0);
      tick();
      check("beq_fallthrough", pc, 16'h0011);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 8'h80);
      #1;
      check("bpl_not_taken", {15'd0, branch_taken}, 16'd0);
      tick();
      check("bpl_fallthrough", pc, 16'h0012);

      // Priority: absolute jump beats branch and increment; old low byte used
      drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 8'h02);
      tick();
      check("priority_jmp", pc, 16'hAB00);

      // Wrap at FFFFh
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      reset_pulse();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      repeat (32) tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      tick();
      check("jmp_ffff", pc, 16'hFFFF);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      tick();
      check("wrap_to_0", pc, 16'h0000);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(99) == 0) begin
            reset_pulse();
         end else begin
            drive(($urandom_range(15) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(1) == 0), ($urandom_range(3) == 0),
                  3'($urandom), 8'($urandom));
            tick();
         end
      end

      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
